// File: rtl/dmem_test_responder_if.sv
// Data-port bus between the single-cycle core (master) and its data memory (slave).
// Load data returns combinationally from the address in the same cycle.
interface dmem_test_responder_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_test_responder.sv
// Data memory for the core's data port with a built-in store-stream judge and watchdog.
// The verdict is registered and sticky until reset. RAM contents survive reset.
module dmem_test_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter logic [31:0] PASS_ADDR    = 32'd100,
    parameter logic [31:0] PASS_DATA    = 32'd25,
    parameter logic [31:0] SCRATCH_ADDR = 32'd96,
    parameter logic [31:0] STATUS_ADDR  = 32'h0000_0400,
    parameter logic [31:0] CYCLE_ADDR   = 32'h0000_0404,
    parameter int unsigned TIMEOUT      = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    dmem_test_responder_if.slave        bus,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [31:0]                 fail_addr,
    output logic [31:0]                 fail_data,
    output logic [15:0]                 store_count
);
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RAM_BYTES  = 32'(DEPTH * 4);
    localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_t;

    state_t      r_state;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_fail_addr;
    logic [31:0] r_fail_data;
    logic [15:0] r_store_count;
    logic [15:0] r_cycle;
    logic [31:0] r_mem [DEPTH];

    logic          w_store;
    logic          w_aligned;
    logic          w_in_range;
    logic          w_pass_hit;
    logic          w_scratch;
    logic          w_bad;
    logic [AW-1:0] w_idx;

    assign w_aligned  = (bus.DataAdr[1:0] == 2'b00);
    assign w_in_range = w_aligned && (bus.DataAdr < RAM_BYTES);
    assign w_idx      = bus.DataAdr[AW+1:2];
    assign w_store    = bus.MemWrite && (r_state == S_RUN);
    assign w_pass_hit = w_aligned && (bus.DataAdr == PASS_ADDR) && (bus.WriteData == PASS_DATA);
    assign w_scratch  = w_aligned && (bus.DataAdr == SCRATCH_ADDR);
    // Misaligned stores match neither qualifier, so they fall into the bad-store path.
    assign w_bad      = !w_pass_hit && !w_scratch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
            r_store_count <= '0;
            r_cycle       <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cycle <= r_cycle + 16'd1;
                    if (bus.MemWrite) begin
                        if (r_store_count != 16'hFFFF)
                            r_store_count <= r_store_count + 16'd1;
                        if (w_pass_hit) begin
                            r_state <= S_PASS;
                            r_pass  <= 1'b1;
                            r_done  <= 1'b1;
                        end else if (w_bad) begin
                            r_state     <= S_FAIL;
                            r_fail      <= 1'b1;
                            r_done      <= 1'b1;
                            r_fail_addr <= bus.DataAdr;
                            r_fail_data <= bus.WriteData;
                        end
                    end else if (r_cycle == LAST_CYCLE) begin
                        r_state   <= S_TMO;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    // No reset on the array: the image is preloaded externally and must persist.
    always_ff @(posedge clk) begin
        if (!reset && w_store && w_in_range)
            r_mem[w_idx] <= bus.WriteData;
    end

    always_comb begin
        bus.ReadData = '0;
        if (w_in_range)
            bus.ReadData = r_mem[w_idx];
        else if (bus.DataAdr == STATUS_ADDR)
            bus.ReadData = {28'b0, r_timeout, r_fail, r_pass, r_done};
        else if (bus.DataAdr == CYCLE_ADDR)
            bus.ReadData = {16'b0, r_cycle};
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign store_count = r_store_count;
endmodule

// File: tb/tb_dmem_test_responder.sv
// Bench for dmem_test_responder: directed scenarios plus random store streams,
// all checked against a behavioural model of the store judge, RAM and watchdog.
module tb_dmem_test_responder;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned P_ADDR   = 100;
    localparam int unsigned P_DATA   = 25;
    localparam int unsigned S_ADDR   = 96;
    localparam int unsigned ST_ADDR  = 32'h400;
    localparam int unsigned CY_ADDR  = 32'h404;
    localparam int unsigned TMO_CYC  = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_addr, fail_data;
    logic [15:0] store_count;

    always #5 clk = ~clk;

    dmem_test_responder_if bus_if ();

    dmem_test_responder #(
        .DEPTH(DEPTH), .PASS_ADDR(32'(P_ADDR)), .PASS_DATA(32'(P_DATA)),
        .SCRATCH_ADDR(32'(S_ADDR)), .STATUS_ADDR(32'(ST_ADDR)),
        .CYCLE_ADDR(32'(CY_ADDR)), .TIMEOUT(TMO_CYC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_addr(fail_addr), .fail_data(fail_data), .store_count(store_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    bit          m_pass, m_fail, m_tmo;
    logic [31:0] m_fa, m_fd;
    int unsigned m_count, m_cycle;
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_done();
        return m_pass || m_fail || m_tmo;
    endfunction

    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        v = 32'h0;
        if (a % 4 == 0 && a < DEPTH * 4) begin
            v = m_mem[a / 4];
            return m_known[a / 4];
        end
        if (a == ST_ADDR)
            v = 32'(m_tmo) * 8 + 32'(m_fail) * 4 + 32'(m_pass) * 2 + 32'(m_done());
        else if (a == CY_ADDR)
            v = 32'(m_cycle);
        return 1'b1;
    endfunction

    task automatic m_clear();
        m_pass = 0; m_fail = 0; m_tmo = 0;
        m_fa = 0; m_fd = 0; m_count = 0; m_cycle = 0;
    endtask

    task automatic m_edge(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd);
        int unsigned c0;
        if (rst) begin
            m_clear();
        end else if (!m_done()) begin
            c0 = m_cycle;
            m_cycle = (m_cycle + 1) % 65536;
            if (we) begin
                if (m_count < 65535) m_count++;
                if (a % 4 != 0) begin
                    m_fail = 1; m_fa = a; m_fd = wd;
                end else begin
                    if (a < DEPTH * 4) begin
                        m_mem[a / 4] = wd;
                        m_known[a / 4] = 1;
                    end
                    if (a == P_ADDR && wd == P_DATA) m_pass = 1;
                    else if (a != S_ADDR) begin
                        m_fail = 1; m_fa = a; m_fd = wd;
                    end
                end
            end else if (c0 == TMO_CYC - 1) begin
                m_tmo = 1;
            end
        end
    endtask

    // One bus cycle: check the pre-edge load, clock, then check registered state.
    task automatic do_cycle(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp;
        bit ok;
        reset = rst;
        bus_if.MemWrite  = we;
        bus_if.DataAdr   = a;
        bus_if.WriteData = wd;
        #1;
        ok = m_read(a, exp);
        if (ok) chk("rd_pre", bus_if.ReadData, exp);
        @(posedge clk);
        m_edge(rst, we, a, wd);
        #1;
        chk("done", 32'(done), 32'(m_done()));
        chk("pass", 32'(pass), 32'(m_pass));
        chk("fail", 32'(fail), 32'(m_fail));
        chk("timeout", 32'(timeout), 32'(m_tmo));
        chk("fail_addr", fail_addr, m_fa);
        chk("fail_data", fail_data, m_fd);
        chk("store_count", 32'(store_count), m_count);
        ok = m_read(a, exp);
        if (ok) chk("rd_post", bus_if.ReadData, exp);
    endtask

    task automatic idle(input int unsigned n, input logic [31:0] a);
        for (int unsigned i = 0; i < n; i++) do_cycle(0, 0, a, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'h0;
            m_known[i] = 0;
        end
        m_clear();
        reset = 1;
        bus_if.MemWrite = 0; bus_if.DataAdr = 0; bus_if.WriteData = 0;
        @(posedge clk); @(posedge clk);
        #1;
        do_cycle(1, 0, 32'(ST_ADDR), 0);
        chk("reset_status", bus_if.ReadData, 32'h0);
        chk("reset_count", 32'(store_count), 32'h0);

        // Scratch then pass store
        do_cycle(0, 1, 32'd96, 32'd7);
        do_cycle(0, 1, 32'd100, 32'd25);
        chk("pass_flag", 32'(pass), 32'h1);
        chk("pass_count", 32'(store_count), 32'd2);
        do_cycle(0, 0, 32'h400, 0);
        chk("pass_status", bus_if.ReadData, 32'h3);
        do_cycle(0, 0, 32'd96, 0);
        chk("ram24", bus_if.ReadData, 32'd7);

        // Wrong pass data, then a sticky verdict
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 32'd100, 32'd26);
        chk("wrong_fail", 32'(fail), 32'h1);
        chk("wrong_faddr", fail_addr, 32'd100);
        chk("wrong_fdata", fail_data, 32'd26);
        do_cycle(0, 1, 32'd100, 32'd25);
        chk("sticky_pass", 32'(pass), 32'h0);
        chk("sticky_cnt", 32'(store_count), 32'd1);
        do_cycle(0, 0, 32'd100, 0);
        chk("ram25", bus_if.ReadData, 32'd26);

        // Misaligned store
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 32'h62, 32'hDEAD_BEEF);
        chk("mis_faddr", fail_addr, 32'h62);
        do_cycle(0, 0, 32'd96, 0);
        chk("mis_noram", bus_if.ReadData, 32'd7);

        // Watchdog
        do_cycle(1, 0, 0, 0);
        idle(TMO_CYC - 1, 32'h404);
        chk("wd_pre", 32'(done), 32'h0);
        do_cycle(0, 0, 32'h404, 0);
        chk("wd_fire", 32'(timeout), 32'h1);
        chk("wd_cycle", bus_if.ReadData, 32'd1000);
        idle(3, 32'h404);
        chk("wd_hold", bus_if.ReadData, 32'd1000);

        // Pass store on the last watchdog cycle wins
        do_cycle(1, 0, 0, 0);
        idle(TMO_CYC - 1, 32'd96);
        do_cycle(0, 1, 32'd100, 32'd25);
        chk("late_pass", 32'(pass), 32'h1);
        chk("late_tmo", 32'(timeout), 32'h0);

        // No write-through; unmapped read
        do_cycle(1, 0, 0, 0);
        do_cycle(0, 1, 32'd96, 32'd5);
        chk("wt_new", bus_if.ReadData, 32'd5);
        do_cycle(0, 0, 32'h300, 0);
        chk("unmapped", bus_if.ReadData, 32'h0);

        // Reset after fail keeps RAM, clears verdict
        do_cycle(0, 1, 32'd8, 32'h1234);
        do_cycle(1, 1, 32'd96, 32'h99);
        chk("rst_fail", 32'(fail), 32'h0);
        do_cycle(0, 0, 32'd96, 0);
        chk("rst_ram", bus_if.ReadData, 32'd5);

        // Random store streams
        for (int run = 0; run < 30; run++) begin
            do_cycle(1, 0, 0, 0);
            for (int c = 0; c < 60; c++) begin
                logic [31:0] a, d;
                bit we, rs;
                int unsigned k;
                k  = $urandom_range(0, 11);
                we = ($urandom_range(0, 3) != 0);
                d  = ($urandom_range(0, 1) != 0) ? 32'(P_DATA) : $urandom;
                rs = ($urandom_range(0, 59) == 0);
                case (k)
                    0, 1, 2, 3, 4: a = 32'(S_ADDR);
                    5:             a = 32'(P_ADDR);
                    6:             a = 32'($urandom_range(0, DEPTH - 1) * 4);
                    7:             a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                    8:             a = 32'(ST_ADDR);
                    9:             a = 32'(CY_ADDR);
                    10:            a = 32'(DEPTH * 4);
                    default:       a = $urandom;
                endcase
                if (k >= 8 && k <= 9) we = 0;
                if (k == 6 || k == 10) we = we && ($urandom_range(0, 3) == 0);
                do_cycle(rs, we, a, d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
